// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the parametrised APB4 memory slave.
package apb_mem_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_mem_state_t;

   localparam int WAIT_W = 4;

   function automatic int byte_lanes(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB4 completer-side bus bundle; the requester drives select/address/data, the slave answers.
interface apb_mem_slave_if
   import apb_mem_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int LANES = byte_lanes(DATA_W);

   logic              PSEL;
   logic              PENABLE;
   logic [ADDR_W-1:0] PADDR;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic [LANES-1:0]  PSTRB;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W storage split into independent byte lanes: per-lane write enable,
// asynchronous read. Contents are deliberately not reset.
module apb_mem_array
   import apb_mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   localparam int LANES = byte_lanes(DATA_W),
   localparam int IW    = $clog2(DEPTH)
) (
   input  logic              PCLK,
   input  logic [LANES-1:0]  i_be,
   input  logic [IW-1:0]     i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      always_ff @(posedge PCLK) begin
         if (i_be[g]) r_mem[i_addr] <= i_wdata[8*g +: 8];
      end

      assign o_rdata[8*g +: 8] = r_mem[i_addr];
   end

endmodule

// File: rtl/apb_mem_slave.sv
// Parametrised APB4 scratch-memory slave with wait states and byte strobes.
// Optional error response (out-of-range / misaligned) enabled by APB_MEM_SLVERR_EN.
module apb_mem_slave
   import apb_mem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic            PCLK,
   input  logic            PRESETn,
   apb_mem_slave_if.slave  bus
);

   localparam int LANES = byte_lanes(DATA_W);
   localparam int LB    = $clog2(LANES);
   localparam int IW    = $clog2(DEPTH);

   apb_mem_state_t       r_state;
   logic [WAIT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]    r_prdata;
   logic                 r_err;

   logic [IW-1:0]        w_idx;
   logic [DATA_W-1:0]    w_rdata;
   logic [LANES-1:0]     w_be;
   logic                 w_err;
   logic                 w_setup;
   logic                 w_done;

   assign w_idx = bus.PADDR[IW+LB-1:LB];

`ifdef APB_MEM_SLVERR_EN
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((64'd1 << LB) - 64'd1);

   // Anything above the index or below word alignment is an error.
   assign w_err = ((bus.PADDR >> (IW + LB)) != '0) || ((bus.PADDR & LOW_MASK) != '0);
`else
   logic w_unused_addr;

   assign w_err         = 1'b0;
   assign w_unused_addr = ^bus.PADDR;
`endif

   assign w_setup     = bus.PSEL && !bus.PENABLE;
   assign bus.PREADY  = (r_state == ACCESS) && (r_cnt == '0) && bus.PSEL;
   assign w_done      = bus.PREADY && bus.PENABLE;
   assign bus.PSLVERR = bus.PREADY && r_err;
   assign bus.PRDATA  = r_prdata;

   // Write commits only on the completion edge, so an abort or reset drops it.
   assign w_be = (w_done && bus.PWRITE && !r_err) ? bus.PSTRB : '0;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_prdata <= '0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_setup) begin
                  r_state <= ACCESS;
                  r_cnt   <= WAIT_W'(WAIT_STATES);
                  r_err   <= w_err;
                  if (!bus.PWRITE) r_prdata <= w_err ? '0 : w_rdata;
               end
            end
            ACCESS: begin
               if (!bus.PSEL)          r_state <= IDLE;
               else if (r_cnt != '0)   r_cnt   <= r_cnt - 1'b1;
               else if (bus.PENABLE)   r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   apb_mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .PCLK    (PCLK),
      .i_be    (w_be),
      .i_addr  (w_idx),
      .i_wdata (bus.PWDATA),
      .o_rdata (w_rdata)
   );

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave: a zero-wait and a 3-wait instance share one driven bus
// with separate selects. Expectations follow APB_MEM_SLVERR_EN when it is defined.
module tb_apb_mem_slave;

`ifdef APB_MEM_SLVERR_EN
   localparam bit SLV = 1'b1;
`else
   localparam bit SLV = 1'b0;
`endif

   logic        PCLK;
   logic        PRESETn;
   logic        psel0, psel3, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;

   int n_vec  = 0;
   int n_miss = 0;

   apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if0 ();
   apb_mem_slave_if #(.ADDR_W(32), .DATA_W(32)) if3 ();

   assign if0.PSEL    = psel0;
   assign if0.PENABLE = penable;
   assign if0.PADDR   = paddr;
   assign if0.PWRITE  = pwrite;
   assign if0.PWDATA  = pwdata;
   assign if0.PSTRB   = pstrb;
   assign if3.PSEL    = psel3;
   assign if3.PENABLE = penable;
   assign if3.PADDR   = paddr;
   assign if3.PWRITE  = pwrite;
   assign if3.PWDATA  = pwdata;
   assign if3.PSTRB   = pstrb;

   apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) u_ws0 (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(if0));
   apb_mem_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(256), .WAIT_STATES(3)) u_ws3 (
      .PCLK(PCLK), .PRESETn(PRESETn), .bus(if3));

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      int          which;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [3:0]  strb;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t tbl[$];

   function automatic logic rdy(input int w);
      return (w != 0) ? if3.PREADY : if0.PREADY;
   endfunction

   function automatic logic serr(input int w);
      return (w != 0) ? if3.PSLVERR : if0.PSLVERR;
   endfunction

   function automatic logic [31:0] rdat(input int w);
      return (w != 0) ? if3.PRDATA : if0.PRDATA;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Ends at the falling edge of the completion cycle so the next call is back-to-back.
   task automatic xfer(input int which, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb,
                       input logic [31:0] exp_rd, input logic exp_err, input string nm);
      int   cyc;
      logic done;
      @(posedge PCLK); #1;
      psel0 = (which == 0); psel3 = (which != 0);
      penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = strb;
      @(posedge PCLK); #1;
      penable = 1'b1;
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 20) begin
         @(negedge PCLK);
         cyc++;
         if (rdy(which)) done = 1'b1;
         else begin
            @(posedge PCLK); #1;
         end
      end
      n_vec++;
      chk({nm, "_cycles"}, cyc, (which != 0) ? 32'd4 : 32'd1);
      if (done) begin
         chk({nm, "_pslverr"}, {31'd0, serr(which)}, {31'd0, exp_err});
         if (!wr) chk({nm, "_prdata"}, rdat(which), exp_rd);
      end
   endtask

   task automatic bus_idle();
      @(posedge PCLK); #1;
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
   endtask

   initial begin
      PRESETn = 1'b0;
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;

      // Fixed-function vectors: {dut, wr, addr, wdata, strb, expected rdata, expected err}
      tbl.push_back('{0, 1'b1, 32'h1000, 32'hABCD1234, 4'hF, 32'h0, SLV});
      tbl.push_back('{0, 1'b0, 32'h1000, 32'h0, 4'h0, SLV ? 32'h0 : 32'hABCD1234, SLV});
      tbl.push_back('{0, 1'b1, 32'h1000, 32'h11223344, 4'h5, 32'h0, SLV});
      tbl.push_back('{0, 1'b0, 32'h1000, 32'h0, 4'h0, SLV ? 32'h0 : 32'hAB221244, SLV});
      tbl.push_back('{0, 1'b1, 32'h0010, 32'hABCD1234, 4'hF, 32'h0, 1'b0});
      tbl.push_back('{0, 1'b1, 32'h0010, 32'h11223344, 4'h5, 32'h0, 1'b0});
      tbl.push_back('{0, 1'b0, 32'h0010, 32'h0, 4'h0, 32'hAB221244, 1'b0});
      tbl.push_back('{0, 1'b1, 32'h0010, 32'hDEADBEEF, 4'h0, 32'h0, 1'b0});
      tbl.push_back('{0, 1'b0, 32'h0010, 32'h0, 4'hF, 32'hAB221244, 1'b0});
      tbl.push_back('{0, 1'b1, 32'h0014, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0});
      tbl.push_back('{0, 1'b0, 32'h0014, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0});
      tbl.push_back('{0, 1'b1, 32'h0000, 32'h01020304, 4'hF, 32'h0, 1'b0});
      tbl.push_back('{0, 1'b1, 32'h0400, 32'h55667788, 4'hF, 32'h0, SLV});
      tbl.push_back('{0, 1'b0, 32'h0000, 32'h0, 4'h0, SLV ? 32'h01020304 : 32'h55667788, 1'b0});
      tbl.push_back('{0, 1'b1, 32'h0002, 32'h99AABBCC, 4'hF, 32'h0, SLV});
      tbl.push_back('{0, 1'b0, 32'h0000, 32'h0, 4'h0, SLV ? 32'h01020304 : 32'h99AABBCC, 1'b0});
      tbl.push_back('{0, 1'b0, 32'h0400, 32'h0, 4'h0, SLV ? 32'h0 : 32'h99AABBCC, SLV});
      tbl.push_back('{1, 1'b1, 32'h0020, 32'hA5A55A5A, 4'hF, 32'h0, 1'b0});
      tbl.push_back('{1, 1'b0, 32'h0020, 32'h0, 4'h0, 32'hA5A55A5A, 1'b0});
      tbl.push_back('{1, 1'b1, 32'h0024, 32'h0F0F0F0F, 4'hF, 32'h0, 1'b0});
      tbl.push_back('{1, 1'b1, 32'h0024, 32'hFFFFFFFF, 4'h9, 32'h0, 1'b0});
      tbl.push_back('{1, 1'b0, 32'h0024, 32'h0, 4'h0, 32'hFF0F0FFF, 1'b0});

      repeat (3) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      n_vec++; chk("rst_pready0",  {31'd0, if0.PREADY},  32'd0);
      n_vec++; chk("rst_pslverr0", {31'd0, if0.PSLVERR}, 32'd0);
      n_vec++; chk("rst_prdata0",  if0.PRDATA,           32'd0);
      n_vec++; chk("rst_pready3",  {31'd0, if3.PREADY},  32'd0);
      n_vec++; chk("rst_prdata3",  if3.PRDATA,           32'd0);

      foreach (tbl[i])
         xfer(tbl[i].which, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].strb,
              tbl[i].rd, tbl[i].err, $sformatf("v%0d", i));
      bus_idle();

      // PRDATA holds across an unrelated write
      xfer(0, 1'b0, 32'h0010, 32'h0, 4'h0, 32'hAB221244, 1'b0, "hold_rd");
      xfer(0, 1'b1, 32'h0018, 32'h12345678, 4'hF, 32'h0, 1'b0, "hold_wr");
      n_vec++; chk("hold_prdata", if0.PRDATA, 32'hAB221244);

      // Select dropped after one access cycle: write must not land
      xfer(1, 1'b1, 32'h0030, 32'h11111111, 4'hF, 32'h0, 1'b0, "abort_base");
      @(posedge PCLK); #1;
      psel0 = 1'b0; psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h0030; pwdata = 32'h22222222; pstrb = 4'hF;
      @(posedge PCLK); #1 penable = 1'b1;
      @(negedge PCLK);
      n_vec++; chk("abort_acc1_pready", {31'd0, if3.PREADY}, 32'd0);
      @(posedge PCLK); #1;
      psel3 = 1'b0; penable = 1'b0;
      @(negedge PCLK);
      n_vec++; chk("abort_drop_pready", {31'd0, if3.PREADY}, 32'd0);
      xfer(1, 1'b0, 32'h0030, 32'h0, 4'h0, 32'h11111111, 1'b0, "abort_rb");
      bus_idle();

      // Reset asserted in the completion cycle discards the pending write
      xfer(0, 1'b1, 32'h0040, 32'h66666666, 4'hF, 32'h0, 1'b0, "rst_base");
      @(posedge PCLK); #1;
      psel0 = 1'b1; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b1;
      paddr = 32'h0040; pwdata = 32'h77777777; pstrb = 4'hF;
      @(posedge PCLK); #1 penable = 1'b1;
      @(negedge PCLK);
      n_vec++; chk("rst_mid_pready_pre", {31'd0, if0.PREADY}, 32'd1);
      #2 PRESETn = 1'b0;
      #1;
      n_vec++; chk("rst_mid_pready", {31'd0, if0.PREADY}, 32'd0);
      n_vec++; chk("rst_mid_prdata", if0.PRDATA, 32'd0);
      @(posedge PCLK); #1;
      psel0 = 1'b0; penable = 1'b0;
      @(posedge PCLK); #1 PRESETn = 1'b1;
      xfer(0, 1'b0, 32'h0040, 32'h0, 4'h0, 32'h66666666, 1'b0, "rst_mid_rb");
      bus_idle();

      repeat (2) @(posedge PCLK);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
